player_hit_controller: RTL

//  Consumes the combinational enemyCollide flag from the collision detector and turns it into game state.

---
 rtl/player_hit_if.sv | 24 ++
 rtl/player_hit_controller.sv | 117 +++++++++++
 2 files changed

// File: rtl/player_hit_if.sv
// player_hit_if: frame/collision/restart inputs and HUD/sprite/FSM outputs of player_hit_controller.
// The master modport drives the inputs; the slave modport is the controller side.
interface player_hit_if #(
    parameter int LIVES_W = 3
);
    logic               frame_tick;
    logic               enemy_collide;
    logic               restart;
    logic [LIVES_W-1:0] lives;
    logic [1:0]         state;
    logic               hit_pulse;
    logic               game_over;
    logic               sprite_visible;

    modport master (
        output frame_tick, enemy_collide, restart,
        input  lives, state, hit_pulse, game_over, sprite_visible
    );

    modport slave (
        input  frame_tick, enemy_collide, restart,
        output lives, state, hit_pulse, game_over, sprite_visible
    );
endinterface

// File: rtl/player_hit_controller.sv
// player_hit_controller: lives, invulnerability window and game-over tracking.
// Define PLAYER_BLINK_EN to blink sprite_visible during the invulnerability window.
module player_hit_controller #(
    parameter int LIVES_INIT    = 3,
    parameter int LIVES_W       = 3,
    parameter int INVULN_FRAMES = 120,
    parameter int BLINK_FRAMES  = 8
) (
    input logic         clk,
    input logic         rst_n,
    player_hit_if.slave bus
);
    localparam logic [1:0] ALIVE    = 2'b00;
    localparam logic [1:0] INVULN   = 2'b01;
    localparam logic [1:0] GAMEOVER = 2'b10;
    localparam int IW = $clog2(INVULN_FRAMES + 1);

    if (LIVES_INIT < 1 || LIVES_INIT > 2**LIVES_W - 1 || INVULN_FRAMES < 1 || BLINK_FRAMES < 1) begin : g_bad_params
        $error("player_hit_controller: illegal parameter values");
    end

    logic [1:0]         state_q, state_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [IW-1:0]      inv_cnt_q, inv_cnt_d;
    logic               hit_pulse_q, hit_pulse_d;
    logic               game_over_q;
    logic               coll_q;
    logic               hit, last_life, timeout;

    assign hit       = !bus.restart && state_q == ALIVE && coll_q;
    assign last_life = lives_q == LIVES_W'(1);
    assign timeout   = state_q == INVULN && bus.frame_tick && inv_cnt_q == IW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ALIVE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.restart) state_d = ALIVE;
        else begin
            case (state_q)
                ALIVE:    if (coll_q) state_d = last_life ? GAMEOVER : INVULN;
                INVULN:   if (timeout) state_d = ALIVE;
                GAMEOVER: state_d = GAMEOVER;
                default:  state_d = ALIVE;
            endcase
        end
    end

    always_comb begin
        lives_d     = bus.restart ? LIVES_W'(LIVES_INIT) : hit ? lives_q - LIVES_W'(1) : lives_q;
        hit_pulse_d = hit;
        inv_cnt_d   = bus.restart ? '0
                    : hit ? (last_life ? '0 : IW'(INVULN_FRAMES))
                    : (state_q == INVULN && bus.frame_tick) ? inv_cnt_q - IW'(1)
                    : inv_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_q      <= 1'b0;
            lives_q     <= LIVES_W'(LIVES_INIT);
            inv_cnt_q   <= '0;
            hit_pulse_q <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            coll_q      <= bus.enemy_collide;
            lives_q     <= lives_d;
            inv_cnt_q   <= inv_cnt_d;
            hit_pulse_q <= hit_pulse_d;
            game_over_q <= state_d == GAMEOVER;
        end
    end

`ifdef PLAYER_BLINK_EN
    localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          sprite_visible_q, sprite_visible_d;

    // Any exit from INVULN (timeout, restart, bad state) shows the sprite again.
    always_comb begin
        blink_cnt_d      = blink_cnt_q;
        sprite_visible_d = sprite_visible_q;
        if (state_d != INVULN) begin
            blink_cnt_d      = '0;
            sprite_visible_d = 1'b1;
        end else if (state_q != INVULN) begin
            blink_cnt_d      = '0;
            sprite_visible_d = 1'b0;
        end else if (bus.frame_tick) begin
            blink_cnt_d      = blink_cnt_q == BW'(BLINK_FRAMES - 1) ? '0 : blink_cnt_q + BW'(1);
            sprite_visible_d = blink_cnt_q == BW'(BLINK_FRAMES - 1) ? !sprite_visible_q : sprite_visible_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q      <= '0;
            sprite_visible_q <= 1'b1;
        end else begin
            blink_cnt_q      <= blink_cnt_d;
            sprite_visible_q <= sprite_visible_d;
        end
    end

    assign bus.sprite_visible = sprite_visible_q;
`else
    assign bus.sprite_visible = 1'b1;
`endif

    assign bus.lives     = lives_q;
    assign bus.state     = state_q;
    assign bus.hit_pulse = hit_pulse_q;
    assign bus.game_over = game_over_q;
endmodule
